// File: rtl/rv32_cpu_issue_aligner_if.sv
// Fetch-side and issue-side handshake bundle for the RV32 issue aligner.
// The aligner uses the slave view; upstream fetch and downstream decode
// (or a testbench) use the master view.
interface rv32_cpu_issue_aligner_if;
   logic        i_fetch_valid;
   logic [31:0] i_fetch_data;
   logic        i_fetch_err;
   logic        o_fetch_ready;
   logic        o_issue_valid;
   logic [31:0] o_issue_instr;
   logic        o_issue_compr;
   logic        o_issue_err;
   logic        i_issue_ready;

   modport master (
      output i_fetch_valid, i_fetch_data, i_fetch_err, i_issue_ready,
      input  o_fetch_ready, o_issue_valid, o_issue_instr, o_issue_compr, o_issue_err
   );

   modport slave (
      input  i_fetch_valid, i_fetch_data, i_fetch_err, i_issue_ready,
      output o_fetch_ready, o_issue_valid, o_issue_instr, o_issue_compr, o_issue_err
   );
endinterface

// File: rtl/rv32_cpu_issue_aligner.sv
// RV32 issue aligner: buffers 32-bit fetch words as halfwords and issues
// whole instructions, expanding 16-bit RVC encodings to their 32-bit form.
// Build option: define RV32_CPU_C_EXT_EN to enable compressed-instruction
// support (decompressor, 16-bit heads, odd-halfword redirect). Without it
// every head is 32-bit and the queue moves in whole words.
// QDEPTH_HW must be 4 or 8.

// RVC to RV32 expansion. Unrecognised encodings come out as the raw halfword
// zero-extended, which the downstream decoder sees as an illegal instruction.
module rv32_cpu_rvc_expand #(
   parameter int FPU_ENABLE = 1
) (
   input  logic [15:0] c,
   output logic [31:0] instr
);
   logic [4:0] rd, rs2, rdp, rs1p;

   assign rd   = c[11:7];
   assign rs2  = c[6:2];
   assign rdp  = {2'b01, c[4:2]};
   assign rs1p = {2'b01, c[9:7]};

   // Decode quadrant and funct3, build the equivalent 32-bit encoding.
   always_comb begin
      instr = {16'h0000, c};
      case (c[1:0])
         2'b00: begin
            case (c[15:13])
               3'b000: if (c[12:5] != 8'h00)
                  instr = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
               3'b010: instr = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'h03};
               3'b011: if (FPU_ENABLE != 0)
                  instr = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'h07};
               3'b110: instr = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
               3'b111: if (FPU_ENABLE != 0)
                  instr = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h27};
               default: ;
            endcase
         end
         2'b01: begin
            case (c[15:13])
               3'b000: instr = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'h13};
               3'b001: instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                                c[12], {8{c[12]}}, 5'd1, 7'h6f};
               3'b010: instr = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'h13};
               3'b011: begin
                  if (rd == 5'd2) begin
                     if ({c[12], c[6:2]} != 6'd0)
                        instr = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'h13};
                  end else if ({c[12], c[6:2]} != 6'd0) begin
                     instr = {{15{c[12]}}, c[6:2], rd, 7'h37};
                  end
               end
               3'b100: begin
                  case (c[11:10])
                     2'b00: instr = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                     2'b01: instr = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                     2'b10: instr = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, 7'h13};
                     default: begin
                        if (!c[12]) begin
                           case (c[6:5])
                              2'b00:   instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                              2'b01:   instr = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
                              2'b10:   instr = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
                              default: instr = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
                           endcase
                        end
                     end
                  endcase
               end
               3'b101: instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                                c[12], {8{c[12]}}, 5'd0, 7'h6f};
               3'b110: instr = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b000, c[11:10], c[4:3], c[12], 7'h63};
               default: instr = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b001, c[11:10], c[4:3], c[12], 7'h63};
            endcase
         end
         2'b10: begin
            case (c[15:13])
               3'b000: instr = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'h13};
               3'b010: if (rd != 5'd0)
                  instr = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
               3'b011: if (FPU_ENABLE != 0)
                  instr = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h07};
               3'b100: begin
                  if (!c[12]) begin
                     if (rs2 == 5'd0) begin
                        if (rd != 5'd0) instr = {12'h000, rd, 3'b000, 5'd0, 7'h67};
                     end else begin
                        instr = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'h33};
                     end
                  end else if (rs2 == 5'd0) begin
                     if (rd == 5'd0) instr = 32'h0010_0073;
                     else            instr = {12'h000, rd, 3'b000, 5'd1, 7'h67};
                  end else begin
                     instr = {7'b0000000, rs2, rd, 3'b000, rd, 7'h33};
                  end
               end
               3'b110: instr = {4'b0000, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
               3'b111: if (FPU_ENABLE != 0)
                  instr = {4'b0000, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h27};
               default: ;
            endcase
         end
         default: ;
      endcase
   end
endmodule

module rv32_cpu_issue_aligner #(
   parameter int FPU_ENABLE = 1,
   parameter int QDEPTH_HW  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic                   i_flush,
   input  logic                   i_flush_pc1,
   rv32_cpu_issue_aligner_if.slave bus
);
   localparam int PTR_W = $clog2(QDEPTH_HW);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(QDEPTH_HW);

   typedef enum logic {ST_RUN, ST_SKIP} state_t;

   state_t           state_q, state_d;
   logic [15:0]      q_data [QDEPTH_HW];
   logic             q_err  [QDEPTH_HW];
   logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
   logic [CNT_W-1:0] count, need_n, pop_amt, push_amt, free_n;
   logic [15:0]      head0, head1;
   logic             head_32, issue_vld, pop, push, fetch_rdy;

   assign rd_ptr1 = rd_ptr + 1'b1;
   assign wr_ptr1 = wr_ptr + 1'b1;
   assign head0   = q_data[rd_ptr];
   assign head1   = q_data[rd_ptr1];

`ifdef RV32_CPU_C_EXT_EN
   logic [31:0] exp_instr;

   rv32_cpu_rvc_expand #(.FPU_ENABLE(FPU_ENABLE)) u_expand (
      .c     (head0),
      .instr (exp_instr)
   );

   assign head_32           = (head0[1:0] == 2'b11);
   assign bus.o_issue_instr = head_32 ? {head1, head0} : exp_instr;
   assign bus.o_issue_compr = ~head_32;
`else
   logic unused_cfg;

   // Without compressed support the redirect halfword and FPU option have no effect.
   assign unused_cfg        = i_flush_pc1 ^ (FPU_ENABLE != 0);
   assign head_32           = 1'b1;
   assign bus.o_issue_instr = {head1, head0};
   assign bus.o_issue_compr = 1'b0;
`endif

   // Issue is a function of registered occupancy only; a flush masks it.
   assign need_n    = head_32 ? CNT_W'(2) : CNT_W'(1);
   assign issue_vld = ~i_flush & (count >= need_n);
   assign pop       = issue_vld & bus.i_issue_ready;
   assign pop_amt   = pop ? need_n : '0;

   // Room is judged after this cycle's pop so a full queue can stream.
   assign free_n    = DEPTH - count + pop_amt;
   assign fetch_rdy = i_rstn & ~i_flush & (free_n >= CNT_W'(2));
   assign push      = bus.i_fetch_valid & fetch_rdy;
   assign push_amt  = !push ? '0 : ((state_q == ST_SKIP) ? CNT_W'(1) : CNT_W'(2));

   assign bus.o_fetch_ready = fetch_rdy;
   assign bus.o_issue_valid = issue_vld;
   assign bus.o_issue_err   = q_err[rd_ptr] | (head_32 & q_err[rd_ptr1]);

   // Next alignment state: a redirect to an odd halfword drops the next low half.
   always_comb begin
      state_d = state_q;
      if (i_flush) begin
`ifdef RV32_CPU_C_EXT_EN
         state_d = i_flush_pc1 ? ST_SKIP : ST_RUN;
`else
         state_d = ST_RUN;
`endif
      end else if (push) begin
         state_d = ST_RUN;
      end
   end

   // Control state: pointers, occupancy and alignment; flush clears the queue.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         state_q <= ST_RUN;
      end else if (i_flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         state_q <= state_d;
      end else begin
         state_q <= state_d;
         count   <= count - pop_amt + push_amt;
         rd_ptr  <= rd_ptr + PTR_W'(pop_amt);
         wr_ptr  <= wr_ptr + PTR_W'(push_amt);
      end
   end

   // Halfword storage, written low half first; contents need no reset.
   always_ff @(posedge i_clk) begin
      if (push) begin
         if (state_q == ST_SKIP) begin
            q_data[wr_ptr]  <= bus.i_fetch_data[31:16];
            q_err[wr_ptr]   <= bus.i_fetch_err;
         end else begin
            q_data[wr_ptr]  <= bus.i_fetch_data[15:0];
            q_err[wr_ptr]   <= bus.i_fetch_err;
            q_data[wr_ptr1] <= bus.i_fetch_data[31:16];
            q_err[wr_ptr1]  <= bus.i_fetch_err;
         end
      end
   end
endmodule

// File: tb/tb_rv32_cpu_issue_aligner.sv
// Directed bench for rv32_cpu_issue_aligner with an expected-issue queue.
// Expectations follow the build: RV32_CPU_C_EXT_EN selects compressed results.
module tb_rv32_cpu_issue_aligner;
   localparam int QD = 4;

   logic clk = 1'b0;
   logic rstn, flush, pc1;

   rv32_cpu_issue_aligner_if bus();

   rv32_cpu_issue_aligner #(.FPU_ENABLE(1), .QDEPTH_HW(QD)) dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_flush     (flush),
      .i_flush_pc1 (pc1),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic        compr;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic        last_acc, last_iss, last_vld, last_rdy;
   logic [31:0] last_instr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic expect_issue(input logic [31:0] i, input logic c, input logic e);
      sb.push_back('{i, c, e});
   endtask

   function automatic logic [31:0] wk(input int k);
      return 32'h0000_0013 | (32'(k) << 20);
   endfunction

   // One clock: sample mid-cycle, score any issue, then advance past the edge.
   task automatic cycle();
      exp_t e;
      #2;
      last_acc   = bus.i_fetch_valid & bus.o_fetch_ready;
      last_vld   = bus.o_issue_valid;
      last_rdy   = bus.o_fetch_ready;
      last_instr = bus.o_issue_instr;
      last_iss   = bus.o_issue_valid & bus.i_issue_ready;
      if (last_iss) begin
         chk1("issue_expected", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("issue_instr", bus.o_issue_instr, e.instr);
            chk1("issue_compr", bus.o_issue_compr, e.compr);
            chk1("issue_err", bus.o_issue_err, e.err);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int maxc);
      for (int i = 0; i < maxc && sb.size() != 0; i++) cycle();
      chk("drain_left", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k, acc_cnt;
      rstn = 1'b0; flush = 1'b0; pc1 = 1'b0;
      bus.i_fetch_valid = 1'b0; bus.i_fetch_data = '0;
      bus.i_fetch_err = 1'b0; bus.i_issue_ready = 1'b1;
      @(posedge clk); #1;

      // reset state
      #2;
      chk1("rst_valid", bus.o_issue_valid, 1'b0);
      chk1("rst_ready", bus.o_fetch_ready, 1'b0);
      @(posedge clk); #1;
      rstn = 1'b1;
      cycle();
      chk1("post_rst_ready", last_rdy, 1'b1);
      chk1("post_rst_valid", last_vld, 1'b0);

      // word 0x00404000
      bus.i_fetch_valid = 1'b1; bus.i_fetch_data = 32'h0040_4000;
`ifdef RV32_CPU_C_EXT_EN
      expect_issue(32'h0004_2403, 1'b1, 1'b0);
      expect_issue(32'h0041_0413, 1'b1, 1'b0);
`else
      expect_issue(32'h0040_4000, 1'b0, 1'b0);
`endif
      cycle();
      chk1("w0_acc", last_acc, 1'b1);
      bus.i_fetch_valid = 1'b0;
      cycle();
      chk1("w0_iss1", last_iss, 1'b1);
`ifdef RV32_CPU_C_EXT_EN
      cycle();
      chk1("w0_iss2", last_iss, 1'b1);
`endif
      cycle();
      chk1("w0_done", last_vld, 1'b0);

      // fetch error carried to issue
      bus.i_fetch_valid = 1'b1; bus.i_fetch_data = 32'h0000_0013; bus.i_fetch_err = 1'b1;
      expect_issue(32'h0000_0013, 1'b0, 1'b1);
      cycle();
      chk1("err_acc", last_acc, 1'b1);
      bus.i_fetch_valid = 1'b0; bus.i_fetch_err = 1'b0;
      cycle();
      chk1("err_iss", last_iss, 1'b1);
      cycle();
      chk1("err_done", last_vld, 1'b0);

      // back-pressure until full, hold, then stream
      bus.i_issue_ready = 1'b0;
      k = 0;
      for (int n = 0; n < 5; n++) begin
         bus.i_fetch_valid = 1'b1; bus.i_fetch_data = wk(k);
         cycle();
         if (last_acc) begin
            expect_issue(wk(k), 1'b0, 1'b0);
            k++;
         end
      end
      chk("full_accepted", 32'(k), 32'(QD / 2));
      chk1("full_ready_low", last_rdy, 1'b0);
      for (int n = 0; n < 3; n++) begin
         cycle();
         chk1("hold_valid", last_vld, 1'b1);
         chk("hold_instr", last_instr, sb[0].instr);
         chk1("hold_ready", last_rdy, 1'b0);
      end
      bus.i_issue_ready = 1'b1;
      acc_cnt = 0;
      for (int n = 0; n < 8; n++) begin
         bus.i_fetch_data = wk(k);
         cycle();
         if (last_acc) begin
            expect_issue(wk(k), 1'b0, 1'b0);
            k++;
            acc_cnt++;
         end
      end
      chk("stream_accepts", 32'(acc_cnt), 32'd8);
      bus.i_fetch_valid = 1'b0;
      drain(16);

      // flush to odd halfword
      bus.i_issue_ready = 1'b0;
      bus.i_fetch_valid = 1'b1; bus.i_fetch_data = 32'h0000_0013;
      cycle();
      chk1("fl_pre_acc", last_acc, 1'b1);
      flush = 1'b1; pc1 = 1'b1; bus.i_issue_ready = 1'b1; bus.i_fetch_data = 32'hdead_beef;
      cycle();
      chk1("fl_valid", last_vld, 1'b0);
      chk1("fl_ready", last_rdy, 1'b0);
      flush = 1'b0; pc1 = 1'b0;
      bus.i_fetch_data = 32'h0040_4000;
`ifdef RV32_CPU_C_EXT_EN
      expect_issue(32'h0041_0413, 1'b1, 1'b0);
`else
      expect_issue(32'h0040_4000, 1'b0, 1'b0);
`endif
      cycle();
      chk1("fl_acc", last_acc, 1'b1);
      bus.i_fetch_valid = 1'b0;
      cycle();
      chk1("fl_iss", last_iss, 1'b1);
      cycle();
      chk1("fl_single", last_vld, 1'b0);

      // reset while an instruction is queued
      bus.i_issue_ready = 1'b0;
      bus.i_fetch_valid = 1'b1; bus.i_fetch_data = wk(7);
      cycle();
      bus.i_fetch_valid = 1'b0;
      rstn = 1'b0;
      #2;
      chk1("mrst_valid", bus.o_issue_valid, 1'b0);
      chk1("mrst_ready", bus.o_fetch_ready, 1'b0);
      @(posedge clk); #1;
      rstn = 1'b1; bus.i_issue_ready = 1'b1;
      cycle();
      chk1("mrst_idle1", last_vld, 1'b0);
      cycle();
      chk1("mrst_idle2", last_vld, 1'b0);
      bus.i_fetch_valid = 1'b1; bus.i_fetch_data = 32'h0000_0013;
      expect_issue(32'h0000_0013, 1'b0, 1'b0);
      cycle();
      bus.i_fetch_valid = 1'b0;
      cycle();
      chk1("mrst_iss", last_iss, 1'b1);

`ifdef RV32_CPU_C_EXT_EN
      // straddling 32-bit instruction across an idle gap
      bus.i_fetch_valid = 1'b1; bus.i_fetch_data = 32'h0013_4000;
      expect_issue(32'h0004_2403, 1'b1, 1'b0);
      cycle();
      bus.i_fetch_valid = 1'b0;
      cycle();
      chk1("st_iss_lw", last_iss, 1'b1);
      cycle();
      chk1("st_idle2", last_vld, 1'b0);
      cycle();
      chk1("st_idle3", last_vld, 1'b0);
      bus.i_fetch_valid = 1'b1; bus.i_fetch_data = 32'h0000_0000;
      expect_issue(32'h0000_0013, 1'b0, 1'b0);
      cycle();
      chk1("st_acc", last_acc, 1'b1);
      bus.i_fetch_valid = 1'b0;
      cycle();
      chk1("st_iss", last_iss, 1'b1);
      flush = 1'b1;
      cycle();
      chk1("st_flush_valid", last_vld, 1'b0);
      flush = 1'b0;

      // reset in the middle of a straddle
      bus.i_fetch_valid = 1'b1; bus.i_fetch_data = 32'h0013_4000;
      expect_issue(32'h0004_2403, 1'b1, 1'b0);
      cycle();
      bus.i_fetch_valid = 1'b0;
      cycle();
      cycle();
      chk1("sr_wait", last_vld, 1'b0);
      rstn = 1'b0;
      #2;
      chk1("sr_valid", bus.o_issue_valid, 1'b0);
      @(posedge clk); #1;
      rstn = 1'b1;
      cycle();
      chk1("sr_idle", last_vld, 1'b0);
      bus.i_fetch_valid = 1'b1; bus.i_fetch_data = 32'h0000_0013;
      expect_issue(32'h0000_0013, 1'b0, 1'b0);
      cycle();
      bus.i_fetch_valid = 1'b0;
      cycle();
      chk1("sr_iss", last_iss, 1'b1);
      cycle();
      chk1("sr_done", last_vld, 1'b0);
`endif

      drain(8);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rv32_cpu_issue_aligner.md
RV32_CPU_ISSUE_ALIGNER -- requirements
Module: rv32_cpu_issue_aligner

Interface
REQ-001 SHALL have parameter FPU_ENABLE, default 1: forwarded to the decompressor instance and enables C.FLW/C.FSW expansion.
REQ-002 SHALL have parameter QDEPTH_HW, default 4: halfword queue depth, legal values 4 or 8.
REQ-003 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 i_rstn  input  1  asynchronous, active-low reset.
REQ-005 i_flush  input  1  discard all queued halfwords (branch or trap redirect).
REQ-006 i_flush_pc1  input  1  bit 1 of the redirect PC, sampled with i_flush.
REQ-007 i_fetch_valid  input  1  fetch word offered.
REQ-008 i_fetch_data  input  32  fetch word, little-endian halfwords.
REQ-009 i_fetch_err  input  1  bus error attached to the fetch word.
REQ-010 o_fetch_ready  output  1  block accepts the fetch word this cycle.
REQ-011 o_issue_valid  output  1  instruction available at o_issue_instr.
REQ-012 o_issue_instr  output  32  expanded 32-bit instruction.
REQ-013 o_issue_compr  output  1  instruction originated from 16 bits.
REQ-014 o_issue_err  output  1  at least one consumed halfword carried a fetch error.
REQ-015 i_issue_ready  input  1  consumer takes the instruction this cycle.

Function
REQ-016 SHALL hold a circular queue of QDEPTH_HW halfwords, each with an error bit, plus a read pointer, a write pointer and an occupancy count (0..QDEPTH_HW).
REQ-017 o_fetch_ready SHALL be 1 when free slots >= 2, i_flush is 0 and i_rstn is 1. Free slots are computed after any pop in the same cycle.
REQ-018 A fetch word SHALL be accepted on (i_fetch_valid & o_fetch_ready) and written as two halfwords, low half first. Each halfword's error bit SHALL equal i_fetch_err.
REQ-019 Head length rule: head[1:0] != 2'b11 means 16-bit, requiring count >= 1. Otherwise the instruction is 32-bit, requiring count >= 2.
REQ-020 o_issue_valid SHALL be 1 when the count meets the head length requirement. It SHALL be driven from registered queue state only, so a word accepted in cycle N is issuable in cycle N+1.
REQ-021 16-bit head: o_issue_instr SHALL be the combinational decompressor expansion of the head, and o_issue_compr SHALL be 1.
REQ-022 32-bit head: o_issue_instr SHALL be {head+1, head}, and o_issue_compr SHALL be 0.
REQ-023 An instruction straddling two fetch words SHALL wait until the upper halfword arrives. o_issue_valid SHALL stay 0 in the meantime.
REQ-024 A pop SHALL occur on (o_issue_valid & i_issue_ready) and remove 1 or 2 halfwords. A push and a pop in the same cycle SHALL both take effect.
REQ-025 Pointers SHALL wrap modulo QDEPTH_HW.
REQ-026 FSM states RUN and SKIP. i_flush SHALL zero count and pointers, and SHALL ignore any fetch in that cycle. The FSM SHALL then enter SKIP if i_flush_pc1 = 1, otherwise RUN.
REQ-027 In SKIP, the next accepted word SHALL write only its upper halfword (count += 1), and the FSM SHALL then return to RUN.
REQ-028 i_flush SHALL take priority over issue: o_issue_valid SHALL be forced to 0 in the flush cycle.
REQ-029 When i_issue_ready = 0, o_issue_valid, o_issue_instr, o_issue_compr and o_issue_err SHALL stay stable while valid.

Reset
REQ-030 While i_rstn = 0: count = 0, pointers = 0, state = RUN, o_issue_valid = 0, o_fetch_ready = 0, queue contents don't-care.
REQ-031 Reset asserted mid-operation SHALL discard partial instructions without issuing them.

Configuration
REQ-032 Macro RV32_CPU_C_EXT_EN. When defined: the decompressor is instantiated and REQ-019, REQ-021, REQ-026 and REQ-027 apply as written.
REQ-033 When undefined, the decompressor SHALL NOT be instantiated, and every head SHALL be treated as 32-bit. In addition:
- o_issue_compr SHALL be tied to 0;
- i_flush_pc1 SHALL be ignored and the FSM SHALL always enter RUN;
- the queue SHALL advance by whole words only.

Verification
REQ-034 Accept fetch word 0x00404000 -> two issues: first 0x00042403 with compr = 1, then 0x00410413 with compr = 1, in consecutive cycles with i_issue_ready = 1.
REQ-035 Fetch 0x00134000, then hold the fetch bus idle 3 cycles, then fetch 0x00000000. Required response:
- 0x00042403 issues first;
- o_issue_valid = 0 during the idle cycles;
- 0x00000013 with compr = 0 issues one cycle after the second word is accepted.
REQ-036 Flush with i_flush_pc1 = 1, then fetch 0x00404000 -> a single issue of 0x00410413. The low half is dropped.
REQ-037 Hold i_issue_ready = 0 with a stream of 32-bit words -> o_fetch_ready falls once the queue is full. Outputs stay stable. No word is lost after ready returns.
REQ-038 Fetch 0x00000013 with i_fetch_err = 1 -> issue 0x00000013 with o_issue_err = 1. Then assert i_rstn = 0 mid-straddle -> no issue until new words arrive.
REQ-039 Build without RV32_CPU_C_EXT_EN and fetch 0x00404000 -> a single issue of 0x00404000 with compr = 0.
